mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit that owns the HI/LO register pair of the

---
 rtl/mult_div_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit holding the HI/LO register pair. It produces
//   one product or quotient bit per cycle. HI/LO are written in a single edge
//   when the operation retires, so their old values stay readable while Busy is
//   high.
//
//   Handshake: Start is a one-cycle request and is sampled only while Busy=0.
//   A MULT*/DIV* request raises Busy for WIDTH+1 cycles. MTHI/MTLO write
//   HI/LO on the accepting edge and never raise Busy. Any request seen while
//   Busy=1 is dropped.
//
//   Ports
//     Clk       in   1      rising-edge clock
//     Rst_n     in   1      asynchronous active-low reset
//     Start     in   1      one-cycle request
//     MdOp      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//     A         in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//     B         in   WIDTH  multiplier / divisor
//     Busy      out  1      MULT/DIV in flight
//     High      out  WIDTH  HI register
//     Low       out  WIDTH  LO register
//     DbgState  out  2      current FSM state (debug observation)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       MdOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] High,
    output logic [WIDTH-1:0] Low,
    output logic [1:0]       DbgState
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // Multiplicand (MUL) or divisor (DIV), magnitude only.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    // MUL: {partial sum, remaining multiplier bits}.
    // DIV: {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 is_div_q, is_div_d;
    // neg_lo: negate product (MUL) or quotient (DIV); neg_hi: negate remainder.
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Combinational helpers for the iteration and sign handling.
    logic                 op_signed;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_fits;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_comb begin
        op_signed = ~MdOp[0];
        abs_a     = (op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
        abs_b     = (op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

        // Shift-add: add the multiplicand when the current multiplier bit is 1.
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

        // Restoring divide: bring down the next dividend bit and trial-subtract.
        // The partial remainder is always below the divisor, so WIDTH+1 bits hold it.
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_fits  = (div_shift >= {1'b0, opnd_q});

        prod_neg  = ~prod_q + 1'b1;
        quo_fix   = neg_lo_q ? (~prod_q[WIDTH-1:0] + 1'b1) : prod_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1)
                             : prod_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    unique case (MdOp)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            opnd_d   = abs_a;
                            prod_d   = {{WIDTH{1'b0}}, abs_b};
                            is_div_d = 1'b0;
                            neg_lo_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_hi_d = 1'b0;
                            bzero_d  = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_DIV;
                            cnt_d    = '0;
                            opnd_d   = abs_b;
                            prod_d   = {{WIDTH{1'b0}}, abs_a};
                            is_div_d = 1'b1;
                            neg_lo_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            // Remainder follows the dividend's sign.
                            neg_hi_d = op_signed & A[WIDTH-1];
                            bzero_d  = (B == '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                prod_d = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                          prod_q[WIDTH-2:0], div_fits};
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_lo_q ? prod_neg : prod_q;
                end else begin
                    // With a zero divisor the remainder path has shifted |A| in
                    // unchanged; restoring its sign gives back A itself.
                    hi_d = rem_fix;
                    lo_d = bzero_q ? {WIDTH{1'b1}} : quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy     = (state_q != S_IDLE);
    assign High     = hi_q;
    assign Low      = lo_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   md_op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic [W-1:0] high;
    logic [W-1:0] low;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0]  exp_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .MdOp(md_op),
        .A(a), .B(b), .Busy(busy), .High(high), .Low(low), .DbgState(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on 64-bit values.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, q, m;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        case (op)
            3'd0: r = sx * sy;
            3'd1: r = {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else r = {x % y, x / y};
            end
            default: r = {model_hi, model_lo};
        endcase
        return r;
    endfunction

    // driver: MULT/DIV family. Called #1 after a rising edge; Start is sampled
    // on the next edge. inject=1 fires an MTLO mid-operation.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit inject);
        logic [63:0] e;
        int n;
        exp_q.push_back(ref_md(op, x, y));
        start = 1'b1; md_op = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", {63'b0, busy}, 64'd1);
        n = 0;
        while (busy && n < 100) begin
            chk("hold_hi", {32'b0, high}, {32'b0, model_hi});
            chk("hold_lo", {32'b0, low}, {32'b0, model_lo});
            a = $urandom;
            b = $urandom;
            if (inject && n == 5) begin
                start = 1'b1; md_op = 3'b101;
            end else begin
                start = 1'b0; md_op = op;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'd33);
        e = exp_q.pop_front();
        chk("result_hi", {32'b0, high}, {32'b0, e[63:32]});
        chk("result_lo", {32'b0, low}, {32'b0, e[31:0]});
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    // driver: MTHI/MTLO or an undefined op while idle
    task automatic do_mt(input logic [2:0] op, input logic [31:0] x);
        start = 1'b1; md_op = op; a = x; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        if (op == 3'b100) model_hi = x;
        else if (op == 3'b101) model_lo = x;
        chk("mt_busy", {63'b0, busy}, 64'd0);
        chk("mt_hi", {32'b0, high}, {32'b0, model_hi});
        chk("mt_lo", {32'b0, low}, {32'b0, model_lo});
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_hi", {32'b0, high}, 64'd0);
        chk("reset_lo", {32'b0, low}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // async reset in the middle of a MULT
        do_mt(3'b100, 32'h1357_9BDF);
        do_mt(3'b101, 32'h2468_ACE0);
        start = 1'b1; md_op = 3'b000; a = 32'd1234; b = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", {63'b0, busy}, 64'd0);
        chk("midreset_hi", {32'b0, high}, 64'd0);
        chk("midreset_lo", {32'b0, low}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("postreset_busy", {63'b0, busy}, 64'd0);
        chk("postreset_hi", {32'b0, high}, 64'd0);
        chk("postreset_lo", {32'b0, low}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        do_op(3'b001, 32'd3, 32'd5, 1'b0);

        // directed corner cases
        do_op(3'b000, 32'hFFFF_FFFE, 32'd7, 1'b0);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(3'b011, 32'd100, 32'd7, 1'b0);
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'b011, 32'h0000_1234, 32'd0, 1'b0);
        do_op(3'b010, 32'hFFFF_FF00, 32'd0, 1'b0);
        do_op(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(3'b010, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // MTHI/MTLO while idle, undefined op ignored, MTLO while busy ignored
        do_mt(3'b100, 32'hAAAA_5555);
        do_mt(3'b101, 32'h0000_0001);
        do_mt(3'b110, 32'hDEAD_BEEF);
        do_mt(3'b111, 32'hCAFE_F00D);
        do_op(3'b000, 32'd12345, 32'hFFFF_0000, 1'b1);

        // back-to-back issue in the cycle after Busy falls
        do_op(3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        do_op(3'b010, 32'h8000_0001, 32'd3, 1'b0);
        do_op(3'b001, 32'h0001_0000, 32'h0001_0000, 1'b0);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 5));
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 15));
                2: r_b = -32'($urandom_range(1, 15));
                default: r_b = $urandom;
            endcase
            if (r_op >= 3'd4) do_mt(r_op, r_a);
            else do_op(r_op, r_a, r_b, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
